// File: rtl/boid_frame_plotter.sv
// boid_frame_plotter: once per frame, erases every boid's previous pixel(s) and
// plots its new position into the framebuffer write port.
// Optional feature: define BOID_PLOT_CROSS_EN to draw each boid as a 5-pixel plus
// (centre, x-1, x+1, y-1, y+1) instead of a single pixel.
module boid_frame_plotter #(
  parameter int unsigned NUM_BOIDS = 16,
  parameter int unsigned WIDTH = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned COLOR_W = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = 8'd31,
  parameter logic [COLOR_W-1:0] BOID_COLOR = 8'd42,
  localparam int unsigned IDX_W = $clog2(NUM_BOIDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  output logic [IDX_W-1:0]   pos_idx,
  input  logic [9:0]         pos_x,
  input  logic [8:0]         pos_y,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_wen,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [2:0] {IDLE, ERASE, FETCH, PLOT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               frame_start_q;
  logic               edge_det;
  logic [ADDR_W-1:0]  shadow_addr [NUM_BOIDS];
  logic [NUM_BOIDS-1:0] shadow_valid;

  logic               in_range;
  logic [ADDR_W-1:0]  centre_addr;
  logic               last_idx;
  logic               entry_end;
  logic               entry_first;
  logic               erase_en;
  logic [ADDR_W-1:0]  erase_addr;
  logic               plot_en;
  logic [ADDR_W-1:0]  plot_addr;

`ifdef BOID_PLOT_CROSS_EN
  // Arm flags per entry: {y+1 ok, y-1 ok, x+1 ok, x-1 ok}
  logic [3:0]         shadow_arms [NUM_BOIDS];
  logic [3:0]         arm_ok;
  logic [2:0]         sub;

  // Address of pixel k of the plus around centre c (0 = centre)
  function automatic logic [ADDR_W-1:0] arm_addr(input logic [ADDR_W-1:0] c, input logic [2:0] k);
    case (k)
      3'd1:    return c - ADDR_W'(1);
      3'd2:    return c + ADDR_W'(1);
      3'd3:    return c - ADDR_W'(WIDTH);
      3'd4:    return c + ADDR_W'(WIDTH);
      default: return c;
    endcase
  endfunction

  // Whether pixel k of the plus is on screen, given the arm flags
  function automatic logic arm_en(input logic [3:0] arms, input logic [2:0] k);
    case (k)
      3'd1:    return arms[0];
      3'd2:    return arms[1];
      3'd3:    return arms[2];
      3'd4:    return arms[3];
      default: return 1'b1;
    endcase
  endfunction
`endif

  // Position decode, per-pixel enables and addresses for the current step
  always_comb begin
    edge_det    = frame_start & ~frame_start_q;
    in_range    = (pos_x < 10'(WIDTH)) && (pos_y < 9'(HEIGHT));
    centre_addr = ADDR_W'(pos_y) * ADDR_W'(WIDTH) + ADDR_W'(pos_x);
    last_idx    = (idx == IDX_W'(NUM_BOIDS - 1));
`ifdef BOID_PLOT_CROSS_EN
    arm_ok[0]   = (pos_x != 10'd0);
    arm_ok[1]   = (11'(pos_x) + 11'd1) < 11'(WIDTH);
    arm_ok[2]   = (pos_y != 9'd0);
    arm_ok[3]   = (10'(pos_y) + 10'd1) < 10'(HEIGHT);
    entry_end   = (sub == 3'd4);
    entry_first = (sub == 3'd0);
    erase_en    = shadow_valid[idx] && arm_en(shadow_arms[idx], sub);
    erase_addr  = arm_addr(shadow_addr[idx], sub);
    plot_en     = in_range && arm_en(arm_ok, sub);
    plot_addr   = arm_addr(centre_addr, sub);
`else
    entry_end   = 1'b1;
    entry_first = 1'b1;
    erase_en    = shadow_valid[idx];
    erase_addr  = shadow_addr[idx];
    plot_en     = in_range;
    plot_addr   = centre_addr;
`endif
  end

`ifdef BOID_PLOT_CROSS_EN
  // Pixel sub-counter walking the five plus pixels of each entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub <= 3'd0;
    end else if (state == ERASE || state == PLOT) begin
      sub <= entry_end ? 3'd0 : sub + 3'd1;
    end else begin
      sub <= 3'd0;
    end
  end

  // Arm flags remembered alongside the centre address for the next erase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_BOIDS); k++) shadow_arms[k] <= 4'd0;
    end else if (state == PLOT && entry_first && in_range) begin
      shadow_arms[idx] <= arm_ok;
    end
  end
`endif

  // Frame FSM with registered framebuffer, handshake and drop-counter outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      frame_start_q <= 1'b0;
      pos_idx       <= '0;
      fb_addr       <= '0;
      fb_data       <= '0;
      fb_wen        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      drop_cnt      <= 8'd0;
      shadow_valid  <= '0;
      for (int k = 0; k < int'(NUM_BOIDS); k++) shadow_addr[k] <= '0;
    end else begin
      frame_start_q <= frame_start;
      fb_wen        <= 1'b0;
      frame_done    <= 1'b0;
      if (edge_det && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (edge_det) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= ERASE;
          end
        end
        ERASE: begin
          if (erase_en) begin
            fb_wen  <= 1'b1;
            fb_addr <= erase_addr;
            fb_data <= BG_COLOR;
          end
          if (entry_end) begin
            if (last_idx) begin
              idx     <= '0;
              pos_idx <= '0;
              state   <= FETCH;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FETCH: begin
          state <= PLOT;
        end
        PLOT: begin
          if (plot_en) begin
            fb_wen  <= 1'b1;
            fb_addr <= plot_addr;
            fb_data <= BOID_COLOR;
          end
          if (entry_first) begin
            if (in_range) begin
              shadow_addr[idx]  <= centre_addr;
              shadow_valid[idx] <= 1'b1;
            end else begin
              shadow_valid[idx] <= 1'b0;
            end
          end
          if (entry_end) begin
            if (last_idx) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx     <= idx + IDX_W'(1);
              pos_idx <= idx + IDX_W'(1);
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_frame_plotter.sv
// Bench for boid_frame_plotter: per-frame expected write lists from a
// coordinate-level model of the erase/plot schedule.
module tb_boid_frame_plotter;
  localparam int N = 16;
  localparam int W = 640;
  localparam int H = 480;
`ifdef BOID_PLOT_CROSS_EN
  localparam int P = 5;
`else
  localparam int P = 1;
`endif
  localparam int L = N * (2 * P + 1) + 1;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
    logic [15:0] cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  pos_idx;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_wen;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  int bx [N];
  int by [N];
  int mx [N];
  int my [N];
  bit mvalid [N];
  int exp_drop = 0;
  wr_t exp_q [$];
  wr_t obs_q [$];

  boid_frame_plotter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pos_idx(pos_idx), .pos_x(pos_x), .pos_y(pos_y),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wen(fb_wen),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Position register file: one-cycle read latency
  always @(posedge clk) begin
    pos_x <= 10'(bx[pos_idx]);
    pos_y <= 9'(by[pos_idx]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_boid(input int x, input int y, input logic [7:0] col, input int base);
    exp_q.push_back('{addr: 19'(y * W + x), data: col, cyc: 16'(base)});
    if (P == 5) begin
      if (x > 0)     exp_q.push_back('{addr: 19'(y * W + x - 1), data: col, cyc: 16'(base + 1)});
      if (x + 1 < W) exp_q.push_back('{addr: 19'(y * W + x + 1), data: col, cyc: 16'(base + 2)});
      if (y > 0)     exp_q.push_back('{addr: 19'((y - 1) * W + x), data: col, cyc: 16'(base + 3)});
      if (y + 1 < H) exp_q.push_back('{addr: 19'((y + 1) * W + x), data: col, cyc: 16'(base + 4)});
    end
  endtask

  // Expected writes for one frame: all erases of last frame's boids, then new plots
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < N; i++)
      if (mvalid[i]) add_boid(mx[i], my[i], 8'd31, 2 + P * i);
    for (int i = 0; i < N; i++) begin
      if (bx[i] < W && by[i] < H) begin
        add_boid(bx[i], by[i], 8'd42, 3 + P * N + (P + 1) * i);
        mx[i] = bx[i]; my[i] = by[i]; mvalid[i] = 1'b1;
      end else begin
        mvalid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input int d1, input int d2, input bit spam);
    int done_cyc, done_n, busy_bad, n;
    build_expected();
    obs_q.delete();
    done_cyc = 0; done_n = 0; busy_bad = 0;
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= L + 3; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (c == d1 || c == d2 || (spam && c >= 2 && c <= L - 1 && (c % 2) == 0)) begin
        frame_start = 1'b1;
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      end
      if (fb_wen) obs_q.push_back('{addr: fb_addr, data: fb_data, cyc: 16'(c)});
      if (frame_done) begin done_n++; done_cyc = c; end
      if (busy !== (c <= L) && busy_bad == 0) busy_bad = c;
    end
    frame_start = 1'b0;
    chk("done_cycle", 64'(done_cyc), 64'(L));
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("busy_first_bad_cycle", 64'(busy_bad), 64'd0);
    chk("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk("write_addr_data_cycle", 64'(obs_q[k]), 64'(exp_q[k]));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  initial begin
    int found;
    reset = 1'b1;
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) begin bx[i] = 0; by[i] = 0; mvalid[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_pos_idx", 64'(pos_idx), 64'd0);
    chk("rst_fb_addr", 64'(fb_addr), 64'd0);
    chk("rst_fb_data", 64'(fb_data), 64'd0);
    chk("rst_fb_wen", 64'(fb_wen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    // Boid i at (i,i); no shadow yet so erase is silent
    for (int i = 0; i < N; i++) begin bx[i] = i; by[i] = i; end
    run_frame(0, 0, 1'b0);

    // Boid 0 moves, boid 3 off-screen, two edges dropped mid-frame
    bx[0] = 5; by[0] = 2; bx[3] = 640; by[3] = 10;
    run_frame(10, 30, 1'b0);
    chk("drop_two", 64'(drop_cnt), 64'd2);

    // Boid 3 to the bottom-right corner pixel
    bx[3] = 639; by[3] = 479;
    run_frame(0, 0, 1'b0);
    found = 0;
    foreach (obs_q[k]) if (obs_q[k].addr == 19'd307199 && obs_q[k].data == 8'd42) found = 1;
    chk("max_addr_plotted", 64'(found), 64'd1);

    // Random positions with some on-edge and off-screen boids
    repeat (4) begin
      for (int i = 0; i < N; i++) begin
        bx[i] = int'($urandom_range(0, 700));
        by[i] = int'($urandom_range(0, 511));
      end
      bx[5] = 0; by[5] = 0; bx[6] = 639; by[6] = 479;
      bx[7] = int'($urandom_range(0, 639)); by[7] = 0;
      run_frame(0, 0, 1'b0);
    end

    // Flood of edges while busy until the drop counter saturates
    while (exp_drop < 255) run_frame(0, 0, 1'b1);
    run_frame(0, 0, 1'b1);
    chk("drop_saturated", 64'(drop_cnt), 64'd255);

    // Reset in the middle of PLOT
    for (int i = 0; i < N; i++) begin
      bx[i] = int'($urandom_range(0, 639));
      by[i] = int'($urandom_range(0, 479));
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (L - 6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_fb_wen", 64'(fb_wen), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 0, 1'b0);
    found = 0;
    foreach (obs_q[k]) if (obs_q[k].data == 8'd31) found++;
    chk("post_reset_erase_writes", 64'(found), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
